// File: rtl/search_arbiter.sv
// search_arbiter
//
// Round-robin scheduler that shares one binary_search engine between
// NUM_REQ requesters. A winner is chosen in IDLE, its key is latched onto
// the engine, the engine's level-sensitive start/found/not_found handshake
// is sequenced, and the result is returned to the granted requester.
//
// Handshake (requester side): a requester raises req with its key and holds
// both until it sees its gnt bit. gnt stays high for the whole transaction.
// Exactly one rsp_valid pulse (one cycle) is returned per grant, even if the
// requester drops req after being granted. req/key are ignored outside IDLE.
//
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   req, key        - per-requester request level and flattened keys
//   gnt             - one-hot grant, held for the transaction
//   rsp_valid       - one-cycle result strobe to the granted requester
//   rsp_found/addr/timeout - result fields, held until the next result
//   busy            - high in every state except IDLE
//   eng_start, eng_A              - engine start level and key
//   eng_L, eng_found, eng_not_found - engine result and flags
//   dbg_state       - current FSM state (IDLE=0, WAIT=1, RESPOND=2, RELEASE=3)
module search_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] key,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_found,
  output logic [ADDR_WIDTH-1:0]         rsp_addr,
  output logic                          rsp_timeout,
  output logic                          busy,
  output logic                          eng_start,
  output logic [DATA_WIDTH-1:0]         eng_A,
  input  logic [ADDR_WIDTH-1:0]         eng_L,
  input  logic                          eng_found,
  input  logic                          eng_not_found,
  output logic [1:0]                    dbg_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PTR_W:0]   NREQ     = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ-1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT-1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic [NUM_REQ-1:0]    w_rot;
  logic [PTR_W-1:0]      w_off;
  logic [PTR_W:0]        w_sum_raw;
  logic [PTR_W:0]        w_sum;
  logic [PTR_W-1:0]      w_win;
  logic [PTR_W-1:0]      w_next_ptr;
  logic [NUM_REQ-1:0]    w_onehot;
  logic [DATA_WIDTH-1:0] w_key;

  assign dbg_state = r_state;

  // Winner selection: rotate the request vector so the pointer position sits
  // at bit 0, take the lowest set bit as an offset, then add the pointer back
  // modulo NUM_REQ.
  always_comb begin
    w_rot = NUM_REQ'({req, req} >> r_ptr);
    w_off = '0;
    for (int j = NUM_REQ-1; j >= 0; j--) begin
      if (w_rot[j]) w_off = PTR_W'(j);
    end
    w_sum_raw = {1'b0, r_ptr} + {1'b0, w_off};
    w_sum     = (w_sum_raw >= NREQ) ? (w_sum_raw - NREQ) : w_sum_raw;
    w_win     = w_sum[PTR_W-1:0];
    w_next_ptr = (w_win == LAST_IDX) ? '0 : (w_win + 1'b1);
    w_onehot = '0;
    w_key    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_win == PTR_W'(j)) begin
        w_onehot[j] = 1'b1;
        w_key       = key[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      gnt         <= '0;
      rsp_valid   <= '0;
      rsp_found   <= 1'b0;
      rsp_addr    <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      eng_start   <= 1'b0;
      eng_A       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_state   <= S_WAIT;
            gnt       <= w_onehot;
            eng_start <= 1'b1;
            eng_A     <= w_key;
            busy      <= 1'b1;
            r_cnt     <= '0;
            r_ptr     <= w_next_ptr;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // found has priority when both flags arrive together; a flag in the
          // last counted cycle still wins over the timeout.
          if (eng_found || eng_not_found || (r_cnt == CNT_LAST)) begin
            r_state     <= S_RESPOND;
            eng_start   <= 1'b0;
            rsp_valid   <= gnt;
            rsp_found   <= eng_found;
            rsp_addr    <= eng_found ? eng_L : '0;
            rsp_timeout <= !(eng_found || eng_not_found);
          end
        end
        S_RESPOND: begin
          r_state   <= S_RELEASE;
          rsp_valid <= '0;
          gnt       <= '0;
        end
        S_RELEASE: begin
          // Stale engine flags must clear before a new start can be issued.
          if (!eng_found && !eng_not_found) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/search_arbiter.md
Name: search_arbiter

Overview:
- Round-robin scheduler that shares one binary_search engine between NUM_REQ requesters.
- Each requester supplies a search key. The arbiter sequences the engine's level-sensitive start / found / not_found handshake and returns the result to the requester it granted.
- Sits between user-side request sources (switch logic, test drivers, future soft clients) and the single binary_search instance in the DE1_SoC top level.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- DATA_WIDTH, 8: search key width; matches the engine's A input.
- ADDR_WIDTH, 5: result address width; matches the engine's L output.
- TIMEOUT, 64: maximum cycles spent in WAIT before the search is aborted.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- key  in  NUM_REQ*DATA_WIDTH  flattened keys; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- rsp_valid  out  NUM_REQ  one-cycle result strobe to the granted requester.
- rsp_found  out  1  result: key present; valid while any rsp_valid bit is 1.
- rsp_addr  out  ADDR_WIDTH  result address; valid while any rsp_valid bit is 1.
- rsp_timeout  out  1  result: engine did not answer within TIMEOUT cycles.
- busy  out  1  high in every state except IDLE.
- eng_start  out  1  engine start level.
- eng_A  out  DATA_WIDTH  key driven to the engine.
- eng_L  in  ADDR_WIDTH  engine result address.
- eng_found  in  1  engine found flag, held until start drops.
- eng_not_found  in  1  engine not-found flag, held until start drops.

Behaviour:
- Reset is asynchronous and active-high. It forces:
  - state IDLE;
  - gnt, rsp_valid, rsp_found, rsp_addr, rsp_timeout, busy, eng_start and eng_A all 0;
  - round-robin pointer 0;
  - timeout counter 0.
- A reset mid-transaction aborts the search immediately. No rsp_valid is issued.
- States are IDLE, WAIT, RESPOND and RELEASE.
- IDLE:
  - If any req bit is high at edge T, select a winner i: the first set bit at or after the pointer, scanning upward with wrap-around.
  - Latch key i into eng_A. At T+1: gnt = 1<<i, eng_start = 1, busy = 1, counter cleared, state WAIT.
  - The pointer updates to (i+1) mod NUM_REQ.
- WAIT:
  - eng_start is held at 1 and eng_A is held stable.
  - If eng_found or eng_not_found is sampled high, go to RESPOND next cycle with:
    - rsp_found = eng_found;
    - rsp_addr = eng_L when found, else 0;
    - rsp_timeout = 0.
  - If both flags are high together, found wins.
  - The counter increments every WAIT cycle. When it reaches TIMEOUT-1 with no flag seen, go to RESPOND with rsp_found = 0, rsp_addr = 0, rsp_timeout = 1.
- RESPOND (exactly one cycle):
  - rsp_valid[i] = 1 and gnt[i] stays 1.
  - eng_start drops to 0 on entry to RESPOND.
  - Next state is RELEASE.
- RELEASE:
  - gnt = 0 and rsp_valid = 0. rsp_* fields hold their last values.
  - Wait until eng_found and eng_not_found are both 0, then go to IDLE.
  - A new request can therefore be granted no earlier than the cycle after the engine returns to idle.
- Latency: request seen to eng_start is 1 cycle. Engine flag seen to rsp_valid is 1 cycle.
- Requester rules:
  - Hold req and key until gnt is seen.
  - A requester that drops req mid-transaction still receives its rsp_valid pulse. The search is never cancelled by the requester.
  - A req still high in IDLE after the response is a new request.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 transactions.
- Changes on req or key outside IDLE are ignored.

Test Plan:
- Single request: req=01, key0=8'hFE, engine answers found with L=5'd31 after 12 cycles -> gnt=01 at the next edge; eng_A=FE; rsp_valid=01 for 1 cycle with rsp_found=1, rsp_addr=31; busy low once the engine flags clear.
- Not found: key0=8'h03, engine raises not_found -> rsp_valid=01, rsp_found=0, rsp_addr=0, rsp_timeout=0.
- Contention with NUM_REQ=2, req=11 held constantly, keys 8'h10/8'h20 -> grants alternate 01,10,01,10 over 4 transactions; eng_A alternates 10,20; every rsp_valid matches the prior gnt.
- Timeout: engine flags tied 0, TIMEOUT=64 -> rsp_valid pulse 64 cycles after gnt with rsp_timeout=1, rsp_found=0; arbiter back in IDLE one cycle later.
- Withdrawal and stale flags: requester 1 drops req 2 cycles after gnt -> still gets rsp_valid=10. Engine holds found 3 cycles after start falls -> arbiter stays in RELEASE 3 cycles and no new grant occurs during them.
- Reset mid-WAIT: assert reset 5 cycles after gnt -> all outputs 0 asynchronously, no rsp_valid; after release, req=10 is granted 10 because the pointer is back at 0 and scans 0 then 1.
